// File: rtl/shake_ctrl.sv
// SHAKE128/256 absorb-and-squeeze controller for a single-block seed: pads the seed,
// drives an external Keccak-f[1600] core and streams rate lanes under valid/ready.
module shake_ctrl #(
   parameter int unsigned SEED_W = 256,
   parameter int unsigned LANE_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [SEED_W-1:0] seed,
   output logic              busy,
   output logic              perm_start,
   output logic [1599:0]     perm_state_in,
   input  logic              perm_done,
   input  logic [1599:0]     perm_state_out,
   output logic [LANE_W-1:0] out_lane,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   input  logic              more,
   input  logic              stop
);

   localparam int unsigned PadBit256 = 136 * 8 - 1;
   localparam int unsigned PadBit128 = 168 * 8 - 1;

   typedef enum logic [2:0] {
      StIdle,
      StLaunch,
      StWaitP,
      StSqueeze,
      StHold
   } state_e;

   state_e          fsm_q, fsm_d;
   logic [1599:0]   st_q, st_d;
   logic [4:0]      k_q, k_d;
   logic            mode_q, mode_d;
   logic [1599:0]   pad_state;
   logic [4:0]      last_k;

   // Seed occupies the low bytes; domain byte 0x1F follows, final rate byte gets 0x80.
   always_comb begin
      pad_state                = '0;
      pad_state[SEED_W-1:0]    = seed;
      pad_state[SEED_W +: 8]   = 8'h1F;
      if (mode) begin
         pad_state[PadBit256] = 1'b1;
      end else begin
         pad_state[PadBit128] = 1'b1;
      end
   end

   assign last_k = mode_q ? 5'd16 : 5'd20;

   always_comb begin
      fsm_d      = fsm_q;
      st_d       = st_q;
      k_d        = k_q;
      mode_d     = mode_q;
      perm_start = 1'b0;
      out_valid  = 1'b0;
      case (fsm_q)
         StIdle: begin
            if (start) begin
               st_d   = pad_state;
               mode_d = mode;
               fsm_d  = StLaunch;
            end
         end
         StLaunch: begin
            perm_start = 1'b1;
            fsm_d      = StWaitP;
         end
         StWaitP: begin
            if (perm_done) begin
               st_d  = perm_state_out;
               k_d   = 5'd0;
               fsm_d = StSqueeze;
            end
         end
         StSqueeze: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (k_q == last_k) begin
                  fsm_d = StHold;
               end else begin
                  k_d = k_q + 5'd1;
               end
            end
         end
         StHold: begin
            // stop has priority over more
            if (stop) begin
               fsm_d = StIdle;
            end else if (more) begin
               fsm_d = StLaunch;
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q  <= StIdle;
         st_q   <= '0;
         k_q    <= 5'd0;
         mode_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         st_q   <= st_d;
         k_q    <= k_d;
         mode_q <= mode_d;
      end
   end

   assign busy          = (fsm_q != StIdle);
   assign perm_state_in = st_q;
   assign out_last      = out_valid && (k_q == last_k);
   assign out_lane      = out_valid ? st_q[{k_q, 6'd0} +: LANE_W] : '0;

endmodule

// File: tb/tb_shake_ctrl.sv
// Bench for shake_ctrl: mock permutation core (bitwise invert after 24 cycles) and a
// lane scoreboard filled from an independent byte-level padding model.
module tb_shake_ctrl;

   typedef struct packed {
      logic [63:0] lane;
      logic        last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [255:0]  seed = '0;
   logic          busy;
   logic          perm_start;
   logic [1599:0] perm_state_in;
   logic          perm_done;
   logic [1599:0] perm_state_out = '0;
   logic [63:0]   out_lane;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          more = 1'b0;
   logic          stop = 1'b0;

   logic          mock_done = 1'b0;
   logic          spur_done = 1'b0;
   logic [1599:0] core_buf = '0;
   int            core_cnt = 0;
   bit            core_busy = 1'b0;
   int            n_pstart = 0;

   int            n_cmp = 0;
   int            n_err = 0;
   beat_t         exp_q[$];
   beat_t         obs_q[$];
   logic [1599:0] model_state;

   shake_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .mode           (mode),
      .seed           (seed),
      .busy           (busy),
      .perm_start     (perm_start),
      .perm_state_in  (perm_state_in),
      .perm_done      (perm_done),
      .perm_state_out (perm_state_out),
      .out_lane       (out_lane),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .more           (more),
      .stop           (stop)
   );

   always #5 clk = ~clk;

   assign perm_done = mock_done | spur_done;

   // Mock core deliberately ignores the controller reset so a stale completion can arrive.
   always @(posedge clk) begin
      mock_done <= 1'b0;
      if (perm_start) begin
         n_pstart  <= n_pstart + 1;
         core_buf  <= perm_state_in;
         core_cnt  <= 24;
         core_busy <= 1'b1;
      end else if (core_busy) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) begin
            mock_done      <= 1'b1;
            perm_state_out <= ~core_buf;
            core_busy      <= 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [1599:0] pad_model(input logic [255:0] s, input bit m);
      logic [7:0]    b[200];
      logic [1599:0] r;
      int            rate;
      foreach (b[i]) b[i] = 8'h00;
      for (int i = 0; i < 32; i++) b[i] = s[8*i +: 8];
      b[32] = 8'h1F;
      rate = m ? 136 : 168;
      b[rate-1] = b[rate-1] | 8'h80;
      for (int i = 0; i < 200; i++) r[8*i +: 8] = b[i];
      return r;
   endfunction

   function automatic int first_diff(input logic [1599:0] a, input logic [1599:0] b);
      for (int i = 0; i < 25; i++) if (a[64*i +: 64] !== b[64*i +: 64]) return i;
      return -1;
   endfunction

   task automatic push_block(input logic [1599:0] st, input bit m);
      int n;
      beat_t bt;
      n = m ? 17 : 21;
      for (int i = 0; i < n; i++) begin
         bt.lane = st[64*i +: 64];
         bt.last = (i == n - 1);
         exp_q.push_back(bt);
      end
   endtask

   task automatic do_start(input bit m, input logic [255:0] s);
      @(negedge clk);
      mode  = m;
      seed  = s;
      start = 1'b1;
      exp_q.delete();
      model_state = ~pad_model(s, m);
      push_block(model_state, m);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic hold_cmd(input bit m, input bit s);
      more = m;
      stop = s;
      @(negedge clk);
      more = 1'b0;
      stop = 1'b0;
   endtask

   // Handshakes one block into obs_q; counts lanes that changed while stalled.
   task automatic drain_block(input int budget, input bit toggle, output int nbad);
      int         cyc;
      bit         done;
      bit         prev_stall;
      logic [63:0] prev_lane;
      beat_t      bt;
      cyc = 0; done = 1'b0; prev_stall = 1'b0; nbad = 0; prev_lane = '0;
      obs_q.delete();
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
         out_ready = toggle ? cyc[0] : 1'b1;
         if (out_valid) begin
            if (prev_stall && out_lane !== prev_lane) nbad++;
            if (out_ready) begin
               bt.lane = out_lane;
               bt.last = out_last;
               obs_q.push_back(bt);
               done = out_last;
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               prev_lane  = out_lane;
            end
         end
      end
   endtask

   task automatic test_reset;
      #1;
      n_cmp++;
      if ({busy, perm_start, out_valid, out_last} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b, want 0000", {busy, perm_start, out_valid, out_last});
      end
      n_cmp++;
      if (out_lane !== 64'h0) begin
         n_err++;
         $display("FAIL reset_lane: got %h, want 0", out_lane);
      end
      n_cmp++;
      if (perm_state_in !== '0) begin
         n_err++;
         $display("FAIL reset_state: lane %0d nonzero, want all zero",
                  first_diff(perm_state_in, '0));
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, perm_start, out_valid} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_release: got %b, want 000", {busy, perm_start, out_valid});
      end
   endtask

   task automatic test_pad_shake256;
      logic [1599:0] tmp;
      beat_t e;
      int nbad;
      do_start(1'b1, '0);
      n_cmp++;
      if (perm_start !== 1'b1) begin
         n_err++;
         $display("FAIL pad_latency: perm_start %b, want 1", perm_start);
      end
      n_cmp++;
      if (perm_state_in[4*64 +: 64] !== 64'h000000000000001F) begin
         n_err++;
         $display("FAIL pad_lane4: got %h, want 000000000000001f", perm_state_in[4*64 +: 64]);
      end
      n_cmp++;
      if (perm_state_in[16*64 +: 64] !== 64'h8000000000000000) begin
         n_err++;
         $display("FAIL pad_lane16: got %h, want 8000000000000000", perm_state_in[16*64 +: 64]);
      end
      tmp = perm_state_in;
      tmp[4*64 +: 64]  = '0;
      tmp[16*64 +: 64] = '0;
      n_cmp++;
      if (tmp !== '0) begin
         n_err++;
         $display("FAIL pad_others: lane %0d nonzero, want 0", first_diff(tmp, '0));
      end
      drain_block(80, 1'b0, nbad);
      n_cmp++;
      if (obs_q.size() !== 17) begin
         n_err++;
         $display("FAIL pad_count: got %0d lanes, want 17", obs_q.size());
      end
      foreach (obs_q[i]) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e) begin
               n_err++;
               $display("FAIL pad_lane[%0d]: got %h/%b, want %h/%b", i, obs_q[i].lane,
                        obs_q[i].last, e.lane, e.last);
            end
         end
      end
      @(negedge clk);
      hold_cmd(1'b0, 1'b1);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL pad_stop: busy %b, want 0", busy);
      end
   endtask

   task automatic test_shake128_stream;
      logic [255:0] s;
      beat_t e;
      int nbad;
      int nlast;
      s = 256'hf8f1_0123_4567_89ab_0011_2233_4455_6677_8899_aabb_ccdd_eeff_6dfe_f500_c966_5598;
      do_start(1'b0, s);
      drain_block(80, 1'b0, nbad);
      n_cmp++;
      if (obs_q.size() !== 21) begin
         n_err++;
         $display("FAIL s128_count: got %0d lanes, want 21", obs_q.size());
      end
      n_cmp++;
      if (obs_q.size() == 0 || obs_q[0].lane !== ~64'h6dfef500c9665598) begin
         n_err++;
         $display("FAIL s128_lane0: got %h, want %h", obs_q.size() ? obs_q[0].lane : 64'hx,
                  ~64'h6dfef500c9665598);
      end
      nlast = 0;
      foreach (obs_q[i]) begin
         if (obs_q[i].last) nlast++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e) begin
               n_err++;
               $display("FAIL s128_lane[%0d]: got %h/%b, want %h/%b", i, obs_q[i].lane,
                        obs_q[i].last, e.lane, e.last);
            end
         end
      end
      n_cmp++;
      if (nlast !== 1 || obs_q.size() == 0 || obs_q[obs_q.size()-1].last !== 1'b1) begin
         n_err++;
         $display("FAIL s128_last: %0d last flags, want exactly 1 on lane 20", nlast);
      end
      @(negedge clk);
      hold_cmd(1'b0, 1'b1);
   endtask

   task automatic test_backpressure;
      beat_t e;
      int nbad;
      do_start(1'b1, {8{$urandom()}});
      drain_block(150, 1'b1, nbad);
      n_cmp++;
      if (obs_q.size() !== 17) begin
         n_err++;
         $display("FAIL bp_count: got %0d handshakes, want 17", obs_q.size());
      end
      n_cmp++;
      if (nbad !== 0) begin
         n_err++;
         $display("FAIL bp_stable: %0d lane changes while stalled, want 0", nbad);
      end
      foreach (obs_q[i]) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e) begin
               n_err++;
               $display("FAIL bp_lane[%0d]: got %h/%b, want %h/%b", i, obs_q[i].lane,
                        obs_q[i].last, e.lane, e.last);
            end
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, out_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL bp_hold: busy/out_valid %b, want 10", {busy, out_valid});
      end
   endtask

   // Continues from HOLD left by test_backpressure.
   task automatic test_more_stop;
      logic [1599:0] prev;
      beat_t e;
      int nbad;
      int p0;
      p0   = n_pstart;
      prev = model_state;
      model_state = ~model_state;
      push_block(model_state, 1'b1);
      hold_cmd(1'b1, 1'b0);
      n_cmp++;
      if (perm_start !== 1'b1) begin
         n_err++;
         $display("FAIL more_launch: perm_start %b, want 1", perm_start);
      end
      n_cmp++;
      if (perm_state_in !== prev) begin
         n_err++;
         $display("FAIL more_state: lane %0d differs from squeezed state",
                  first_diff(perm_state_in, prev));
      end
      drain_block(80, 1'b0, nbad);
      n_cmp++;
      if (obs_q.size() !== 17) begin
         n_err++;
         $display("FAIL more_count: got %0d lanes, want 17", obs_q.size());
      end
      foreach (obs_q[i]) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e) begin
               n_err++;
               $display("FAIL more_lane[%0d]: got %h/%b, want %h/%b", i, obs_q[i].lane,
                        obs_q[i].last, e.lane, e.last);
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (n_pstart - p0 !== 1) begin
         n_err++;
         $display("FAIL more_pulses: %0d perm_start pulses, want 1", n_pstart - p0);
      end
      hold_cmd(1'b1, 1'b1);
      n_cmp++;
      if ({busy, out_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL stop_wins: busy/out_valid %b, want 00", {busy, out_valid});
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (n_pstart - p0 !== 1) begin
         n_err++;
         $display("FAIL stop_relaunch: %0d perm_start pulses, want 1", n_pstart - p0);
      end
   endtask

   task automatic test_reset_midrun;
      int bad;
      int p0;
      do_start(1'b0, {8{$urandom()}});
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({busy, perm_start, out_valid, out_last} !== 4'b0000 || out_lane !== 64'h0 ||
          perm_state_in !== '0) begin
         n_err++;
         $display("FAIL midrst_async: ctrl %b lane %h, want all zero",
                  {busy, perm_start, out_valid, out_last}, out_lane);
      end
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      p0  = n_pstart;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         spur_done = (i == 3);
         if (busy || out_valid || perm_start || out_last || out_lane !== 64'h0) bad++;
      end
      spur_done = 1'b0;
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL midrst_idle: %0d active cycles after release, want 0", bad);
      end
      n_cmp++;
      if (n_pstart !== p0) begin
         n_err++;
         $display("FAIL midrst_pstart: %0d pulses, want 0", n_pstart - p0);
      end
   endtask

   task automatic test_start_ignored;
      logic [255:0] s;
      beat_t e;
      int nbad;
      int p0;
      s  = {8{$urandom()}};
      p0 = n_pstart;
      out_ready = 1'b0;
      do_start(1'b0, s);
      for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
      start = 1'b1;
      mode  = 1'b1;
      seed  = ~s;
      @(negedge clk);
      start = 1'b0;
      drain_block(80, 1'b0, nbad);
      n_cmp++;
      if (obs_q.size() !== 21) begin
         n_err++;
         $display("FAIL busy_start_count: got %0d lanes, want 21", obs_q.size());
      end
      foreach (obs_q[i]) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e) begin
               n_err++;
               $display("FAIL busy_start_lane[%0d]: got %h/%b, want %h/%b", i, obs_q[i].lane,
                        obs_q[i].last, e.lane, e.last);
            end
         end
      end
      @(negedge clk);
      hold_cmd(1'b0, 1'b1);
      n_cmp++;
      if (n_pstart - p0 !== 1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_start_pulses: %0d pulses busy %b, want 1 and 0",
                  n_pstart - p0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_pad_shake256();
      test_shake128_stream();
      test_backpressure();
      test_more_stop();
      test_reset_midrun();
      test_start_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shake_ctrl.md
SHAKE_CTRL -- requirements
Module: shake_ctrl

Interface
REQ-001 Parameter SEED_W, default 256, seed width in bits (32 bytes, Kyber rho/sigma seed).
REQ-002 Parameter LANE_W, default 64, width of one Keccak lane and of the output stream.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new SHAKE run; sampled only in IDLE.
REQ-006 mode  input  1  0 = SHAKE128 (rate 168 B, 21 lanes), 1 = SHAKE256 (rate 136 B, 17 lanes); sampled with start.
REQ-007 seed  input  SEED_W  message bytes; byte i = seed[8i+7:8i]; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 perm_start  output  1  one-cycle pulse launching the 24-round permutation core.
REQ-010 perm_state_in  output  1600  state presented to the core; lane i = bits [64i+63:64i], i = x+5y.
REQ-011 perm_done  input  1  core completion strobe; perm_state_out is valid in the same cycle.
REQ-012 perm_state_out  input  1600  permuted state from the core.
REQ-013 out_lane  output  LANE_W  current squeezed lane.
REQ-014 out_valid  output  1  out_lane valid.
REQ-015 out_ready  input  1  consumer accepts out_lane when high together with out_valid.
REQ-016 out_last  output  1  high with the final rate lane of the current block.
REQ-017 more  input  1  in HOLD, request one more squeeze block.
REQ-018 stop  input  1  in HOLD, terminate the run.

Function
REQ-019 FSM states SHALL be IDLE, LAUNCH, WAIT_P, SQUEEZE, HOLD.
REQ-020 IDLE: on start=1, SHALL load 1600-bit state register with padded seed, latch mode, go to LAUNCH next cycle.
REQ-021 Padding: bytes 0..31 = seed, byte 32 = 0x1F, byte R-1 |= 0x80 (R = 168 or 136), all other bytes 0.
REQ-022 perm_state_in SHALL always equal the state register.
REQ-023 LAUNCH: perm_start=1 for exactly this one cycle, then WAIT_P.
REQ-024 WAIT_P: on perm_done=1, SHALL capture perm_state_out into state register, reset lane index k to 0, go to SQUEEZE.
REQ-025 perm_done SHALL be ignored in every state other than WAIT_P.
REQ-026 SQUEEZE: out_valid=1, out_lane = state[64k+63:64k]; out_last = (k == R/8-1).
REQ-027 On out_valid&out_ready, k SHALL increment; out_lane SHALL hold stable while out_ready=0.
REQ-028 Handshake on last lane SHALL go to HOLD; k SHALL never exceed R/8-1.
REQ-029 HOLD: out_valid=0; stop=1 -> IDLE; else more=1 -> LAUNCH (re-permute captured state, no re-absorb).
REQ-030 more and stop both high in HOLD: stop SHALL win.
REQ-031 start while busy=1 SHALL be ignored; seed/mode changes while busy SHALL have no effect.
REQ-032 Latency: start at edge t -> perm_start high in cycle t+1; first out_valid in cycle after the perm_done capture edge.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, state register 0, k=0, mode 0, and busy, perm_start, out_valid, out_last, out_lane all 0.
REQ-034 Reset mid-run (any state) SHALL discard the run; no perm_start or out_valid after release until a new start.

Verification
REQ-035 mode=1, seed=0, start -> next cycle perm_start=1, lane 4 = 0x000000000000001F, lane 16 = 0x8000000000000000, all other lanes 0.
REQ-036 mode=0, seed=256'hf8f1...5598, mock core returns input XOR all-ones after 24 cycles -> 21 lanes streamed, lane 0 = ~64'h6dfef500c9665598, out_last only on lane 20.
REQ-037 SHAKE256 run with out_ready toggling every other cycle -> exactly 17 handshakes, out_lane stable while stalled, then HOLD.
REQ-038 HOLD with more=1 -> exactly one perm_start, core input equals previously squeezed state, second 17-lane block; then more=1 and stop=1 together -> IDLE, busy=0.
REQ-039 Assert rst=0 during WAIT_P, spurious perm_done after release -> outputs stay 0, FSM stays IDLE.
REQ-040 start pulsed during SQUEEZE with new seed -> ignored; streamed lanes unchanged.
